translated_read_arbiter: RTL and testbench
==========================================

# translated_read_arbiter

Shares one translated, addressed read port among REQUESTER_COUNT requesters. Each requester presents a full-width address. The arbiter grants one requester round-robin, translates the address into an index relative to INPUT_BASE_ADDR, and selects one word of the packed input bus. It returns the registered word with a one-cycle acknowledge. It sits between several pipeline/IO clients and a bank of memory-mapped input words.

## Interface
- WORD_WIDTH, 36, width of one input word
- ADDR_WIDTH, 11, width of requester addresses
- INPUT_COUNT, 8, number of words on the packed input bus
- INPUT_BASE_ADDR, 123, address of word 0
- INPUT_ADDR_WIDTH, 3, clog2(INPUT_COUNT)
- REQUESTER_COUNT, 4, number of requesters
- REQUESTER_WIDTH, 2, clog2(REQUESTER_COUNT)
- clock  in  1  sole clock; all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- req  in  REQUESTER_COUNT  per-requester read request level
- req_addr  in  REQUESTER_COUNT*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- in  in  INPUT_COUNT*WORD_WIDTH  packed input words; word j at [j*WORD_WIDTH +: WORD_WIDTH]
- ack  out  REQUESTER_COUNT  one-hot, one-cycle completion pulse to granted requester
- ack_miss  out  1  high with ack when address fell outside the window
- rd_data  out  WORD_WIDTH  read result, valid while any ack bit is high, held otherwise
- busy  out  1  high in GRANT and RESPOND states

## Operation
- FSM states: IDLE, GRANT, RESPOND.
- IDLE: if any req bit is high, select the first set bit scanning upward from pointer p, wrapping modulo REQUESTER_COUNT. Latch grant index g and req_addr[g]. Go to GRANT. Otherwise stay in IDLE.
- GRANT: compute offset = latched_addr − INPUT_BASE_ADDR modulo 2^ADDR_WIDTH.
  - Hit: offset < INPUT_COUNT. Register rd_data = word[offset[INPUT_ADDR_WIDTH-1:0]] and ack_miss = 0.
  - Miss: register rd_data = 0 and ack_miss = 1.
  - Register ack = one-hot(g). Go to RESPOND.
- RESPOND: ack and ack_miss are high for this cycle only. Set p = (g+1) mod REQUESTER_COUNT. Go to IDLE.
- Requesters must hold req and req_addr stable until ack. The address is latched in IDLE, so later changes do not affect the in-flight read.
- A req still high in the cycle after ack is a new request, arbitrated normally. The pointer has advanced, so that requester now has the lowest priority.
- The input bus is sampled only in GRANT. Any later change to `in` does not alter rd_data.
- Dropping req before ack is illegal. The arbiter completes the latched read regardless.

## Timing
- Reset (clear high at an edge): state = IDLE, p = 0, ack = 0, ack_miss = 0, rd_data = 0, busy = 0. Any in-flight read is discarded without ack. This holds mid-GRANT and mid-RESPOND.
- Latency: req sampled in IDLE at edge k → ack high in cycle k+2, i.e. 2 cycles after the grant decision.
- Throughput: one read per 3 cycles under continuous demand.
- All outputs are registered. There is no combinational path from req, req_addr or in to any output.
- Simultaneous requests: exactly one is granted per pass. Others wait, and each waits at most REQUESTER_COUNT−1 passes.
- Address arithmetic wraps at ADDR_WIDTH bits. An address below the base wraps to a large offset and is a miss.
- The last valid hit address is INPUT_BASE_ADDR+INPUT_COUNT−1.

## Configuration
- Macro TRANSLATED_READ_ARBITER_RANGE_CHECK_EN.
- Defined: hit/miss detection is as described above, and misses return 0 with ack_miss = 1.
- Undefined:
  - There is no range check and ack_miss is tied to 0.
  - Index = offset[INPUT_ADDR_WIDTH-1:0], so addresses alias every 2^INPUT_ADDR_WIDTH.
  - An index ≥ INPUT_COUNT returns 0.

## Test plan
- Reset then single read: req[0] = 1, addr 125, word 2 = 36'h0_1234_5678 → ack = 4'b0001 at cycle k+2, rd_data = 36'h0_1234_5678, ack_miss = 0, busy high for 2 cycles.
- All four requesters hold req from reset with addresses 123..126 → acks in order 0, 1, 2, 3, then 0 again. Acks are spaced 3 cycles apart, and each returns the word matching its address.
- Bounds with RANGE_CHECK_EN:
  - addr 122 → ack_miss = 1, rd_data = 0.
  - addr 131 → miss.
  - addr 130 → hit on word 7.
- Wrap without RANGE_CHECK_EN: addr 131 returns word 0 with ack_miss = 0.
- clear asserted during GRANT of requester 2 → no ack that cycle or the next. All outputs are 0 and p = 0. Requester 2, still requesting, is granted 2 cycles after clear deasserts.
- `in` changes one cycle after GRANT → rd_data keeps the value sampled in GRANT. Changing req_addr[g] after latch → the response uses the latched address.

Source files
------------

// File: rtl/translated_read_arbiter.sv
// translated_read_arbiter
//
// Lets REQUESTER_COUNT clients share one read port onto a packed bus of
// INPUT_COUNT memory-mapped words. A round-robin pointer chooses one
// requester. Its address is latched and translated into a word index
// relative to INPUT_BASE_ADDR. The selected word comes back registered,
// together with a one-cycle one-hot acknowledge. A pass takes three cycles:
// IDLE (arbitrate and latch), GRANT (translate and sample the bus) and
// RESPOND (ack visible, pointer advances).
//
// Ports
//   clock     in   sole clock, rising edge
//   clear     in   synchronous active-high reset
//   req       in   [REQUESTER_COUNT]              per-requester request level
//   req_addr  in   [REQUESTER_COUNT*ADDR_WIDTH]   packed requester addresses
//   in        in   [INPUT_COUNT*WORD_WIDTH]       packed input words
//   ack       out  [REQUESTER_COUNT]              one-hot completion pulse
//   ack_miss  out  address fell outside the window (qualified by ack)
//   rd_data   out  [WORD_WIDTH]                   read result, held between acks
//   busy      out  high in GRANT and RESPOND
//
// Build option
//   TRANSLATED_READ_ARBITER_RANGE_CHECK_EN
//     When defined, an offset >= INPUT_COUNT is a miss: it returns 0 with
//     ack_miss set. When undefined, the low INPUT_ADDR_WIDTH offset bits
//     index the bus directly, so addresses alias every 2**INPUT_ADDR_WIDTH.
//     In that case ack_miss is always 0.

module translated_read_arbiter #(
  parameter int WORD_WIDTH       = 36,
  parameter int ADDR_WIDTH       = 11,
  parameter int INPUT_COUNT      = 8,
  parameter int INPUT_BASE_ADDR  = 123,
  parameter int INPUT_ADDR_WIDTH = 3,
  parameter int REQUESTER_COUNT  = 4,
  parameter int REQUESTER_WIDTH  = 2
) (
  input  logic                                  clock,
  input  logic                                  clear,
  input  logic [REQUESTER_COUNT-1:0]            req,
  input  logic [REQUESTER_COUNT*ADDR_WIDTH-1:0] req_addr,
  input  logic [INPUT_COUNT*WORD_WIDTH-1:0]     in,
  output logic [REQUESTER_COUNT-1:0]            ack,
  output logic                                  ack_miss,
  output logic [WORD_WIDTH-1:0]                 rd_data,
  output logic                                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RESPOND} state_t;

  state_t                      state_q, state_d;
  logic [REQUESTER_WIDTH-1:0]  ptr_q, ptr_d;
  logic [REQUESTER_WIDTH-1:0]  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [REQUESTER_COUNT-1:0]  ack_q, ack_d;
  logic                        miss_q, miss_d;
  logic [WORD_WIDTH-1:0]       data_q, data_d;

  // Round-robin pick: first set request at or above the pointer, wrapping.
  logic                        pick_vld;
  logic [REQUESTER_WIDTH-1:0]  pick_idx;
  logic [REQUESTER_WIDTH-1:0]  cand_idx;
  int                          cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      cand     = (int'(ptr_q) + i) % REQUESTER_COUNT;
      cand_idx = REQUESTER_WIDTH'(cand);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Word table padded to a power of two. Slots past INPUT_COUNT read as zero,
  // so an aliased index that lands beyond the bus returns 0.
  logic [WORD_WIDTH-1:0] word_tab [2**INPUT_ADDR_WIDTH];

  for (genvar j = 0; j < 2**INPUT_ADDR_WIDTH; j++) begin : g_tab
    if (j < INPUT_COUNT) begin : g_word
      assign word_tab[j] = in[j*WORD_WIDTH +: WORD_WIDTH];
    end else begin : g_zero
      assign word_tab[j] = '0;
    end
  end

  // Translation: the subtraction wraps at ADDR_WIDTH bits, so an address
  // below the base becomes a large offset.
  logic [ADDR_WIDTH-1:0]       offset;
  logic [INPUT_ADDR_WIDTH-1:0] rd_idx;
  logic                        hit;

  assign offset = addr_q - ADDR_WIDTH'(INPUT_BASE_ADDR);
  assign rd_idx = offset[INPUT_ADDR_WIDTH-1:0];

`ifdef TRANSLATED_READ_ARBITER_RANGE_CHECK_EN
  assign hit = (offset < ADDR_WIDTH'(INPUT_COUNT));
`else
  // Only the low offset bits matter when aliasing.
  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[ADDR_WIDTH-1:INPUT_ADDR_WIDTH];
  assign hit = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ack_d   = '0;
    miss_d  = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The bus is sampled only here; later changes do not reach rd_data.
        data_d         = hit ? word_tab[rd_idx] : '0;
        miss_d         = ~hit;
        ack_d[grant_q] = 1'b1;
        state_d        = RESPOND;
      end
      RESPOND: begin
        // The just-served requester drops to lowest priority.
        ptr_d   = (grant_q == REQUESTER_WIDTH'(REQUESTER_COUNT - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      miss_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      miss_q  <= miss_d;
      data_q  <= data_d;
    end
    // Grant index and address are only consumed after a fresh latch in IDLE.
    grant_q <= grant_d;
    addr_q  <= addr_d;
  end

  assign ack      = ack_q;
  assign ack_miss = miss_q;
  assign rd_data  = data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_translated_read_arbiter.sv
module tb_translated_read_arbiter;

  localparam int WW   = 36;
  localparam int AW   = 11;
  localparam int IC   = 8;
  localparam int BASE = 123;
  localparam int IAW  = 3;
  localparam int RC   = 4;
  localparam int RW   = 2;

  logic              clock = 1'b0;
  logic              clear;
  logic [RC-1:0]     req;
  logic [RC*AW-1:0]  req_addr;
  logic [IC*WW-1:0]  in_bus;
  logic [RC-1:0]     ack;
  logic              ack_miss;
  logic [WW-1:0]     rd_data;
  logic              busy;

  always #5 clock = ~clock;

  translated_read_arbiter #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .INPUT_COUNT(IC), .INPUT_BASE_ADDR(BASE),
    .INPUT_ADDR_WIDTH(IAW), .REQUESTER_COUNT(RC), .REQUESTER_WIDTH(RW)
  ) dut (
    .clock(clock), .clear(clear), .req(req), .req_addr(req_addr), .in(in_bus),
    .ack(ack), .ack_miss(ack_miss), .rd_data(rd_data), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: a pass is a 3-cycle transaction. Requests are
  // arbitrated when no pass is in flight; the answer is computed from the
  // address arithmetic and the bus contents one cycle after the grant and
  // appears for exactly one cycle.
  int            m_ptr  = 0;
  int            m_left = 0;   // cycles until the pass is finished
  int            m_g    = 0;
  logic [AW-1:0] m_addr = '0;
  logic [RC-1:0] e_ack  = '0;
  logic          e_miss = 1'b0;
  logic [WW-1:0] e_data = '0;
  logic          e_busy = 1'b0;

  function automatic logic [WW-1:0] word_of(input int j);
    return in_bus[j*WW +: WW];
  endfunction

  task automatic model_edge();
    int off;
    int idx;
    if (clear) begin
      m_ptr = 0; m_left = 0;
      e_ack = '0; e_miss = 1'b0; e_data = '0;
    end else begin
      e_ack  = '0;
      e_miss = 1'b0;
      if (m_left == 2) begin
        off = (int'(m_addr) - BASE + (1 << AW)) % (1 << AW);
`ifdef TRANSLATED_READ_ARBITER_RANGE_CHECK_EN
        if (off < IC) begin e_data = word_of(off); e_miss = 1'b0; end
        else          begin e_data = '0;           e_miss = 1'b1; end
`else
        idx    = off % (1 << IAW);
        e_data = (idx < IC) ? word_of(idx) : '0;
`endif
        e_ack  = RC'(1) << m_g;
        m_left = 1;
      end else if (m_left == 1) begin
        m_ptr  = (m_g + 1) % RC;
        m_left = 0;
      end else if (req != '0) begin
        for (int k = 0; k < RC; k++) begin
          if (m_left == 0 && req[(m_ptr + k) % RC]) begin
            m_g    = (m_ptr + k) % RC;
            m_addr = req_addr[m_g*AW +: AW];
            m_left = 2;
          end
        end
      end
    end
    e_busy = (m_left != 0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
    check("ack",      ack,      e_ack);
    check("ack_miss", ack_miss, e_miss);
    check("rd_data",  rd_data,  e_data);
    check("busy",     busy,     e_busy);
  endtask

  task automatic set_addr(input int r, input int a);
    req_addr[r*AW +: AW] = AW'(a);
  endtask

  task automatic reset_pulse();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  logic [WW-1:0] saved;
  logic [RC-1:0] active;
  int            bnd_addr [3] = '{122, 131, 130};

  initial begin
    clear    = 1'b1;
    req      = '0;
    req_addr = '0;
    in_bus   = '0;
    for (int j = 0; j < IC; j++) in_bus[j*WW +: WW] = 36'hA_0000_0000 | WW'(j);

    // Reset state, then a single read.
    reset_pulse();
    check("reset_ack",  ack,     '0);
    check("reset_busy", busy,    1'b0);
    check("reset_data", rd_data, '0);
    in_bus[2*WW +: WW] = 36'h0_1234_5678;
    req = 4'b0001; set_addr(0, 125);
    cycle();
    check("t1_busy_grant", busy, 1'b1);
    check("t1_ack_early",  ack,  '0);
    cycle();
    check("t1_ack",  ack,      4'b0001);
    check("t1_data", rd_data,  36'h0_1234_5678);
    check("t1_miss", ack_miss, 1'b0);
    check("t1_busy", busy,     1'b1);
    req = '0;
    cycle();
    check("t1_idle", busy, 1'b0);
    cycle();

    // All four requesters from reset, addresses 123..126.
    for (int j = 0; j < IC; j++) in_bus[j*WW +: WW] = 36'hA_0000_0000 | WW'(j);
    clear = 1'b1;
    for (int r = 0; r < RC; r++) set_addr(r, BASE + r);
    req = 4'b1111;
    cycle();
    clear = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      cycle();
      if (n % 3 == 2) begin
        check("rr_ack",  ack,     RC'(1) << ((n / 3) % RC));
        check("rr_data", rd_data, 36'hA_0000_0000 | WW'((n / 3) % RC));
      end else begin
        check("rr_noack", ack, '0);
      end
    end
    req = '0;
    cycle(); cycle();

    // Window boundaries.
    for (int b = 0; b < 3; b++) begin
      req = 4'b0010; set_addr(1, bnd_addr[b]);
      cycle(); cycle();
      check("bnd_ack", ack, 4'b0010);
`ifdef TRANSLATED_READ_ARBITER_RANGE_CHECK_EN
      check("bnd_miss", ack_miss, (b == 2) ? 1'b0 : 1'b1);
      check("bnd_data", rd_data,  (b == 2) ? 36'hA_0000_0007 : 36'h0);
`else
      check("wrap_miss", ack_miss, 1'b0);
      check("wrap_data", rd_data,  (b == 1) ? 36'hA_0000_0000 : 36'hA_0000_0007);
`endif
      req = '0;
      cycle(); cycle();
    end

    // clear while requester 2 is in GRANT.
    reset_pulse();
    req = 4'b0100; set_addr(2, 124);
    cycle();
    check("clr_busy_pre", busy, 1'b1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clr_ack0",  ack,      '0);
    check("clr_busy",  busy,     1'b0);
    check("clr_data",  rd_data,  '0);
    check("clr_miss",  ack_miss, 1'b0);
    cycle();
    check("clr_ack1",  ack,      '0);
    cycle();
    check("clr_regrant", ack,     4'b0100);
    check("clr_rdata",   rd_data, 36'hA_0000_0001);
    req = '0;
    cycle(); cycle();

    // Address and bus changes after the latch do not disturb the read.
    req = 4'b0010; set_addr(1, 127);
    cycle();
    set_addr(1, 123);
    saved = in_bus[4*WW +: WW];
    cycle();
    check("lat_ack",  ack,     4'b0010);
    check("lat_data", rd_data, saved);
    req = '0;
    for (int j = 0; j < IC; j++) in_bus[j*WW +: WW] = {4'($urandom), 32'($urandom)};
    cycle();
    check("hold_data", rd_data, saved);
    cycle();

    // Randomized traffic with protocol-abiding requesters.
    active = '0;
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < RC; r++) begin
        if (e_ack[r]) active[r] = 1'b0;
        if (!active[r] && $urandom_range(0, 3) == 0) begin
          active[r] = 1'b1;
          if ($urandom_range(0, 9) == 0) req_addr[r*AW +: AW] = AW'($urandom);
          else set_addr(r, BASE - 3 + int'($urandom_range(0, 14)));
        end
      end
      req = active;
      for (int j = 0; j < IC; j++) in_bus[j*WW +: WW] = {4'($urandom), 32'($urandom)};
      clear = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
